if_id_inst_queue: RTL and testbench

- Dual-issue instruction queue between the IF stage and the ID stage.
- Accepts 0–2 fetched {pc, inst} entries per cycle on line1/line2 and presents the oldest 0–2 entries to ID as line1/line2 with valids.
- Decouples fetch from decode stalls.
- Flushed on exception or branch-mispredict redirect.

---
 rtl/if_id_inst_queue.sv | 165 ++++++++++++++++
 tb/tb_if_id_inst_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_inst_queue.sv
// if_id_inst_queue
//   Dual-issue instruction queue sitting between IF and ID. Up to two
//   {pc, inst} entries enter per cycle and the oldest two leave per cycle.
//   A flush (exception or branch redirect) empties the queue.
//
//   Optional statistics counters are compiled in when the macro
//   IF_ID_QUEUE_STAT_EN is defined; without it the ports and counters are
//   absent and the core behaviour is unchanged.
//
//   Handshake: the IF side pushes its valid lines only in a cycle where
//   pre_allowin_o is high (that cycle always has room for two entries);
//   lines offered while pre_allowin_o is low are ignored and IF must hold
//   them. The ID side takes every valid output line in a cycle where
//   now_allowin_i is high; while it is low the outputs are held stable.
//   A flush in a cycle overrides both push and pop.

module if_id_inst_queue #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 64,
    parameter int PTR_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line1_pre_valid_i,
    input  logic               line2_pre_valid_i,
    input  logic [ENTRY_W-1:0] line1_pre_ibus,
    input  logic [ENTRY_W-1:0] line2_pre_ibus,
    output logic               pre_allowin_o,
    input  logic               now_allowin_i,
    output logic               line1_now_valid_o,
    output logic               line2_now_valid_o,
    output logic [ENTRY_W-1:0] line1_to_id_obus,
    output logic [ENTRY_W-1:0] line2_to_id_obus,
    input  logic               excep_flush_i,
    input  logic               branch_flush_i,
    output logic [PTR_W:0]     count_o
`ifdef IF_ID_QUEUE_STAT_EN
    ,
    output logic [31:0]        stat_full_cycles_o,
    output logic [15:0]        stat_flush_cnt_o
`endif
);

    localparam int CNT_W = PTR_W + 1;

    // Registered state
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    // Per-cycle control
    logic       flush;
    logic [1:0] push_req;
    logic [1:0] pushes;
    logic [1:0] pops;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p1;

    assign flush     = excep_flush_i | branch_flush_i;
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

    // Output side: everything comes from registers, no fetch-to-decode bypass.
    always_comb begin
        pre_allowin_o     = (count_q <= CNT_W'(DEPTH - 2)) & ~flush;
        line1_now_valid_o = (count_q >= CNT_W'(1)) & ~flush;
        line2_now_valid_o = (count_q >= CNT_W'(2)) & ~flush;
        line1_to_id_obus  = mem_q[rd_ptr_q];
        line2_to_id_obus  = mem_q[rd_ptr_p1];
        count_o           = count_q;
    end

    // Push and pop amounts for this cycle.
    always_comb begin
        push_req = {1'b0, line1_pre_valid_i} + {1'b0, line2_pre_valid_i};
        pushes   = pre_allowin_o ? push_req : 2'd0;
        pops     = now_allowin_i
                   ? ({1'b0, line1_now_valid_o} + {1'b0, line2_now_valid_o})
                   : 2'd0;
    end

    // Next pointers and occupancy; flush returns everything to the empty state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pops);
            wr_ptr_d = wr_ptr_q + PTR_W'(pushes);
            count_d  = count_q + CNT_W'(pushes) - CNT_W'(pops);
        end
    end

    // Storage writes: line1 goes first; a lone line2 takes the line1 slot.
    always_comb begin
        mem_d = mem_q;
        if (!flush && pre_allowin_o) begin
            case ({line2_pre_valid_i, line1_pre_valid_i})
                2'b01: mem_d[wr_ptr_q] = line1_pre_ibus;
                2'b10: mem_d[wr_ptr_q] = line2_pre_ibus;
                2'b11: begin
                    mem_d[wr_ptr_q]  = line1_pre_ibus;
                    mem_d[wr_ptr_p1] = line2_pre_ibus;
                end
                default: ;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef IF_ID_QUEUE_STAT_EN
    logic [31:0] stat_full_q, stat_full_d;
    logic [15:0] stat_flush_q, stat_flush_d;

    // Saturating counters: stalled-fetch cycles (outside flush) and flush cycles.
    always_comb begin
        stat_full_d  = stat_full_q;
        stat_flush_d = stat_flush_q;
        if (!flush && !pre_allowin_o && (push_req != 2'd0) && (stat_full_q != '1)) begin
            stat_full_d = stat_full_q + 32'd1;
        end
        if (flush && (stat_flush_q != '1)) begin
            stat_flush_d = stat_flush_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_full_q  <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_full_q  <= stat_full_d;
            stat_flush_q <= stat_flush_d;
        end
    end

    assign stat_full_cycles_o = stat_full_q;
    assign stat_flush_cnt_o   = stat_flush_q;
`endif

endmodule

// File: tb/tb_if_id_inst_queue.sv
// tb_if_id_inst_queue
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-of-entries reference model. Connects the statistics ports when
//   IF_ID_QUEUE_STAT_EN is defined.

module tb_if_id_inst_queue;

  localparam int DEPTH   = 8;
  localparam int ENTRY_W = 64;
  localparam int PTR_W   = 3;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut signals
  logic               l1v, l2v;
  logic [ENTRY_W-1:0] d1, d2;
  logic               allow_in;
  logic               ef, bf;
  logic               pre_allowin_o;
  logic               line1_now_valid_o, line2_now_valid_o;
  logic [ENTRY_W-1:0] line1_to_id_obus, line2_to_id_obus;
  logic [PTR_W:0]     count_o;
`ifdef IF_ID_QUEUE_STAT_EN
  logic [31:0]        stat_full_cycles_o;
  logic [15:0]        stat_flush_cnt_o;
  int                 exp_full_cycles;
  int                 exp_flush_cnt;
`endif

  if_id_inst_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .PTR_W(PTR_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .line1_pre_valid_i (l1v),
    .line2_pre_valid_i (l2v),
    .line1_pre_ibus    (d1),
    .line2_pre_ibus    (d2),
    .pre_allowin_o     (pre_allowin_o),
    .now_allowin_i     (allow_in),
    .line1_now_valid_o (line1_now_valid_o),
    .line2_now_valid_o (line2_now_valid_o),
    .line1_to_id_obus  (line1_to_id_obus),
    .line2_to_id_obus  (line2_to_id_obus),
    .excep_flush_i     (ef),
    .branch_flush_i    (bf),
    .count_o           (count_o)
`ifdef IF_ID_QUEUE_STAT_EN
    ,
    .stat_full_cycles_o(stat_full_cycles_o),
    .stat_flush_cnt_o  (stat_flush_cnt_o)
`endif
  );

  // scoreboard: entries currently held, oldest first
  logic [ENTRY_W-1:0] exp_q[$];
  int n_vectors;
  int n_miscompares;
  logic [31:0] pc_ctr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk_ent(input logic [31:0] pc);
    return {pc, $urandom()};
  endfunction

  // One clock cycle: drive, check combinational outputs against the model,
  // then advance the model across the rising edge.
  task automatic cycle(input logic v1, input logic v2,
                       input logic [ENTRY_W-1:0] e1, input logic [ENTRY_W-1:0] e2,
                       input logic alw, input logic f_ex, input logic f_br);
    int   sz;
    int   npop;
    logic fl, ea, ev1, ev2;
    @(negedge clk);
    l1v = v1; l2v = v2; d1 = e1; d2 = e2;
    allow_in = alw; ef = f_ex; bf = f_br;
    #1;
    sz  = exp_q.size();
    fl  = f_ex | f_br;
    ea  = (sz <= DEPTH - 2) && !fl;
    ev1 = (sz >= 1) && !fl;
    ev2 = (sz >= 2) && !fl;
    check_eq("count", 64'(count_o), 64'(sz));
    check_eq("allowin", 64'(pre_allowin_o), 64'(ea));
    check_eq("valid1", 64'(line1_now_valid_o), 64'(ev1));
    check_eq("valid2", 64'(line2_now_valid_o), 64'(ev2));
    if (ev1) check_eq("obus1", line1_to_id_obus, exp_q[0]);
    if (ev2) check_eq("obus2", line2_to_id_obus, exp_q[1]);
`ifdef IF_ID_QUEUE_STAT_EN
    check_eq("stat_full", 64'(stat_full_cycles_o), 64'(exp_full_cycles));
    check_eq("stat_flush", 64'(stat_flush_cnt_o), 64'(exp_flush_cnt));
`endif
    @(posedge clk);
`ifdef IF_ID_QUEUE_STAT_EN
    if (fl) exp_flush_cnt++;
    if (!fl && !ea && (v1 || v2)) exp_full_cycles++;
`endif
    if (fl) begin
      exp_q.delete();
    end else begin
      npop = alw ? (int'(ev1) + int'(ev2)) : 0;
      for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
      if (ea) begin
        if (v1) exp_q.push_back(e1);
        if (v2) exp_q.push_back(e2);
      end
    end
    #1;
  endtask

  task automatic flush_cycle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_stalled(input logic v1, input logic v2, input logic [31:0] pc1, input logic [31:0] pc2);
    cycle(v1, v2, mk_ent(pc1), mk_ent(pc2), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int allow_pct;
    logic v1, v2, alw, fx, fb;
    n_vectors = 0;
    n_miscompares = 0;
    pc_ctr = 32'h1c00_1000;
`ifdef IF_ID_QUEUE_STAT_EN
    exp_full_cycles = 0;
    exp_flush_cnt = 0;
`endif
    l1v = 0; l2v = 0; d1 = '0; d2 = '0; allow_in = 0; ef = 0; bf = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_allowin", 64'(pre_allowin_o), 64'd1);
    check_eq("rst_valid1", 64'(line1_now_valid_o), 64'd0);
    check_eq("rst_valid2", 64'(line2_now_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first pair after reset, ID stalled
    push_stalled(1, 1, 32'h1c00_0000, 32'h1c00_0004);
    check_eq("tp1_count", 64'(count_o), 64'd2);
    check_eq("tp1_v1", 64'(line1_now_valid_o), 64'd1);
    check_eq("tp1_v2", 64'(line2_now_valid_o), 64'd1);
    check_eq("tp1_pc1", 64'(line1_to_id_obus[63:32]), 64'h1c00_0000);
    check_eq("tp1_pc2", 64'(line2_to_id_obus[63:32]), 64'h1c00_0004);

    // fill from empty with ID stalled
    flush_cycle();
    for (int i = 0; i < 3; i++) push_stalled(1, 1, 32'h1c00_0100 + 8 * i, 32'h1c00_0104 + 8 * i);
    check_eq("tp2_count6", 64'(count_o), 64'd6);
    check_eq("tp2_allow6", 64'(pre_allowin_o), 64'd1);
    push_stalled(1, 1, 32'h1c00_0118, 32'h1c00_011c);
    check_eq("tp2_count8", 64'(count_o), 64'd8);
    check_eq("tp2_allow8", 64'(pre_allowin_o), 64'd0);
    push_stalled(1, 1, 32'h1c00_0120, 32'h1c00_0124);
    check_eq("tp2_hold8", 64'(count_o), 64'd8);

    // count 3, pop two while pushing one
    flush_cycle();
    push_stalled(1, 1, 32'h0000_000a, 32'h0000_000b);
    push_stalled(1, 0, 32'h0000_000c, 32'h0);
    cycle(1, 0, mk_ent(32'h0000_000d), '0, 1'b1, 1'b0, 1'b0);
    check_eq("tp3_count", 64'(count_o), 64'd2);
    check_eq("tp3_pc1", 64'(line1_to_id_obus[63:32]), 64'h0000_000c);
    check_eq("tp3_pc2", 64'(line2_to_id_obus[63:32]), 64'h0000_000d);

    // wrap: reach rd=7, wr=1, count=2, then drain
    flush_cycle();
    for (int i = 0; i < 3; i++) push_stalled(1, 1, 32'h2000_0000 + 8 * i, 32'h2000_0004 + 8 * i);
    push_stalled(1, 0, 32'h2000_0018, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1, 1, mk_ent(32'h2000_001c), mk_ent(32'h2000_0020), 1'b1, 1'b0, 1'b0);
    check_eq("wrap_count", 64'(count_o), 64'd2);
    check_eq("wrap_pc1", 64'(line1_to_id_obus[63:32]), 64'h2000_001c);
    check_eq("wrap_pc2", 64'(line2_to_id_obus[63:32]), 64'h2000_0020);
    cycle(0, 0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("wrap_empty", 64'(count_o), 64'd0);
    check_eq("wrap_v1", 64'(line1_now_valid_o), 64'd0);

    // branch flush at count 5 with push and pop requested
    for (int i = 0; i < 2; i++) push_stalled(1, 1, 32'h3000_0000 + 8 * i, 32'h3000_0004 + 8 * i);
    push_stalled(1, 0, 32'h3000_0010, 32'h0);
    check_eq("tp5_count5", 64'(count_o), 64'd5);
    cycle(1, 1, mk_ent(32'h3000_0020), mk_ent(32'h3000_0024), 1'b1, 1'b0, 1'b1);
    check_eq("tp5_count0", 64'(count_o), 64'd0);

    // lone line2 into empty queue
    push_stalled(0, 1, 32'h0, 32'h1c00_0010);
    check_eq("tp6_count", 64'(count_o), 64'd1);
    check_eq("tp6_pc1", 64'(line1_to_id_obus[63:32]), 64'h1c00_0010);
    check_eq("tp6_v2", 64'(line2_now_valid_o), 64'd0);

    // random traffic in phases of different ID back-pressure
    for (int ph = 0; ph < 16; ph++) begin
      allow_pct = $urandom_range(10, 100);
      for (int c = 0; c < 100; c++) begin
        v1  = 1'($urandom_range(0, 1));
        v2  = 1'($urandom_range(0, 1));
        alw = ($urandom_range(0, 99) < allow_pct);
        fx  = ($urandom_range(0, 63) == 0);
        fb  = ($urandom_range(0, 47) == 0);
        cycle(v1, v2, mk_ent(pc_ctr), mk_ent(pc_ctr + 32'd4), alw, fx, fb);
        pc_ctr = pc_ctr + 32'd8;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
